// File: rtl/plot_arbiter.sv
// plot_arbiter: round-robin serialiser of lane pixel writes onto the single
// vga_adapter plot port, with an on-demand full-screen clear sweep.
module plot_arbiter #(
    parameter int         NUM_REQ   = 4,
    parameter int         X_MAX     = 159,
    parameter int         Y_MAX     = 119,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   x_in,
    input  logic [7*NUM_REQ-1:0]   y_in,
    input  logic [3*NUM_REQ-1:0]   colour_in,
    output logic [NUM_REQ-1:0]     grant,
    input  logic                   clear_req,
    output logic                   clear_busy,
    output logic [7:0]             x,
    output logic [6:0]             y,
    output logic [2:0]             colour,
    output logic                   plot
);

    localparam int         PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] XMAX8 = 8'(X_MAX);
    localparam logic [6:0] YMAX7 = 7'(Y_MAX);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t          state_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   rr_ptr_d;
    logic [7:0]      cx_q;
    logic [6:0]      cy_q;
    logic            done_q;
    logic [7:0]      x_q;
    logic [6:0]      y_q;
    logic [2:0]      colour_q;
    logic            plot_q;
    logic            busy_q;

    logic            grantValid;
    logic [PW-1:0]   grantIdx;
    logic [PW-1:0]   sel;
    logic [7:0]      selX;
    logic [6:0]      selY;
    logic [2:0]      selC;
    logic            inRange;

    // Pick the first requesting lane starting at the round-robin pointer;
    // nothing is granted in reset, during a sweep, or when a clear is requested.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        sel        = '0;
        grant      = '0;
        if (resetn && state_q == ARB && !clear_req) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                sel = PW'((int'(rr_ptr_q) + k) % NUM_REQ);
                if (!grantValid && req[sel]) begin
                    grantValid = 1'b1;
                    grantIdx   = sel;
                end
            end
        end
        if (grantValid) begin
            grant[grantIdx] = 1'b1;
        end
        selX     = x_in[8*grantIdx +: 8];
        selY     = y_in[7*grantIdx +: 7];
        selC     = colour_in[3*grantIdx +: 3];
        inRange  = (selX <= XMAX8) && (selY <= YMAX7);
        rr_ptr_d = (grantIdx == PW'(NUM_REQ - 1)) ? '0 : grantIdx + PW'(1);
    end

    // Arbitration/sweep state machine; every output to the adapter is registered here.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            done_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ARB: begin
                    if (clear_req) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        cx_q    <= '0;
                        cy_q    <= '0;
                        done_q  <= 1'b0;
                        plot_q  <= 1'b0;
                    end else if (grantValid) begin
                        rr_ptr_q <= rr_ptr_d;
                        if (inRange) begin
                            x_q      <= selX;
                            y_q      <= selY;
                            colour_q <= selC;
                            plot_q   <= 1'b1;
                        end else begin
                            plot_q   <= 1'b0;
                        end
                    end else begin
                        plot_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (done_q) begin
                        state_q <= ARB;
                        busy_q  <= 1'b0;
                        plot_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        x_q      <= cx_q;
                        y_q      <= cy_q;
                        colour_q <= BG_COLOUR;
                        plot_q   <= 1'b1;
                        if (cx_q == XMAX8) begin
                            cx_q <= '0;
                            if (cy_q == YMAX7) begin
                                done_q <= 1'b1;
                            end else begin
                                cy_q <= cy_q + 7'd1;
                            end
                        end else begin
                            cx_q <= cx_q + 8'd1;
                        end
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign clear_busy = busy_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Self-checking bench for plot_arbiter: a pixel-level reference model plus
// directed scenarios with hand-computed literal expectations.
module tb_plot_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] x_in = '0;
    logic [27:0] y_in = '0;
    logic [11:0] colour_in = '0;
    logic [3:0]  grant;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;

    int compared = 0;
    int mismatched = 0;
    bit checkEn = 1'b0;

    // Reference model state: pointer, sweep progress, expected registered outputs
    int mPtr = 0;
    bit mClear = 1'b0;
    int mIdx = 0;
    bit ePlot = 1'b0;
    bit eBusy = 1'b0;
    int ex = 0;
    int ey = 0;
    int ec = 0;

    plot_arbiter dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .grant      (grant),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Index of the lane the model expects to win, or -1 for no grant
    function automatic int modelWinner();
        if (!resetn || mClear || clear_req) return -1;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (mPtr + k) % 4;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic int modelGrant();
        int w;
        w = modelWinner();
        return (w < 0) ? 0 : (1 << w);
    endfunction

    // Advance the model at each rising edge from the inputs it sees there
    always @(posedge clk) begin
        int w;
        w = modelWinner();
        if (!resetn) begin
            mPtr = 0; mClear = 0; mIdx = 0;
            ePlot = 0; eBusy = 0; ex = 0; ey = 0; ec = 0;
        end else if (!mClear) begin
            if (clear_req) begin
                mClear = 1; mIdx = 0; eBusy = 1; ePlot = 0;
            end else if (w >= 0) begin
                int px, py;
                px = int'(x_in[8*w +: 8]);
                py = int'(y_in[7*w +: 7]);
                mPtr = (w + 1) % 4;
                if (px <= 159 && py <= 119) begin
                    ePlot = 1; ex = px; ey = py; ec = int'(colour_in[3*w +: 3]);
                end else begin
                    ePlot = 0;
                end
            end else begin
                ePlot = 0;
            end
        end else begin
            if (mIdx < 160 * 120) begin
                ex = mIdx % 160; ey = mIdx / 160; ec = 0; ePlot = 1;
                mIdx++;
            end else begin
                mClear = 0; eBusy = 0; ePlot = 0;
            end
        end
    end

    // Compare the DUT against the model on every falling edge
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("modelGrant", int'(grant), modelGrant());
            checkOutput("modelPlot", int'(plot), int'(ePlot));
            checkOutput("modelBusy", int'(clear_busy), int'(eBusy));
            if (ePlot) begin
                checkOutput("modelX", int'(x), ex);
                checkOutput("modelY", int'(y), ey);
                checkOutput("modelColour", int'(colour), ec);
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] r, input logic clr);
        @(posedge clk);
        #1;
        req = r;
        clear_req = clr;
    endtask

    task automatic setLane(input int i, input int px, input int py, input int pc);
        x_in[8*i +: 8] = 8'(px);
        y_in[7*i +: 7] = 7'(py);
        colour_in[3*i +: 3] = 3'(pc);
    endtask

    initial begin
        int cnt;
        int lastX, lastY, lastC;
        bit seenDone;

        for (int i = 0; i < 4; i++) setLane(i, 10 + i, 20 + i, i + 1);

        // Reset held for three cycles
        @(posedge clk);
        #1 checkEn = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstPlot", int'(plot), 0);
        checkOutput("rstGrant", int'(grant), 0);
        checkOutput("rstBusy", int'(clear_busy), 0);
        checkOutput("rstX", int'(x), 0);
        checkOutput("rstY", int'(y), 0);
        checkOutput("rstColour", int'(colour), 0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // All lanes requesting for eight cycles: strict rotation 0,1,2,3,...
        applyStimulus(4'b1111, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("rotGrant", int'(grant), 1 << (k % 4));
            if (k > 0) begin
                checkOutput("rotPlot", int'(plot), 1);
                checkOutput("rotX", int'(x), 10 + ((k - 1) % 4));
            end
        end
        applyStimulus(4'b0000, 1'b0);
        @(negedge clk);
        checkOutput("rotLastPlot", int'(plot), 1);
        checkOutput("rotLastX", int'(x), 13);
        checkOutput("rotLastY", int'(y), 23);

        // Single lane 2 pixel, one-cycle latency
        setLane(2, 25, 40, 3'b101);
        applyStimulus(4'b0100, 1'b0);
        @(negedge clk);
        checkOutput("singleGrant", int'(grant), 4'b0100);
        applyStimulus(4'b0000, 1'b0);
        @(negedge clk);
        checkOutput("singlePlot", int'(plot), 1);
        checkOutput("singleX", int'(x), 25);
        checkOutput("singleY", int'(y), 40);
        checkOutput("singleColour", int'(colour), 5);

        // Out-of-range pixel on lane 1: granted, dropped, pointer moves to 2
        setLane(1, 200, 10, 2);
        applyStimulus(4'b0010, 1'b0);
        @(negedge clk);
        checkOutput("oorGrant", int'(grant), 4'b0010);
        applyStimulus(4'b0000, 1'b0);
        @(negedge clk);
        checkOutput("oorPlot", int'(plot), 0);
        applyStimulus(4'b1111, 1'b0);
        @(negedge clk);
        checkOutput("oorPtrGrant", int'(grant), 4'b0100);
        applyStimulus(4'b0000, 1'b0);

        // Clear sweep started together with a lane 0 request
        applyStimulus(4'b0001, 1'b1);
        @(negedge clk);
        checkOutput("clrPrioGrant", int'(grant), 0);
        applyStimulus(4'b0001, 1'b0);
        cnt = 0; lastX = -1; lastY = -1; lastC = -1; seenDone = 0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (plot) begin
                cnt++;
                if (cnt == 1) begin
                    checkOutput("sweepFirstX", int'(x), 0);
                    checkOutput("sweepFirstY", int'(y), 0);
                end
                lastX = int'(x); lastY = int'(y); lastC = int'(colour);
            end
            if (!clear_busy) begin
                seenDone = 1;
                break;
            end
        end
        checkOutput("sweepEnded", int'(seenDone), 1);
        checkOutput("sweepCount", cnt, 19200);
        checkOutput("sweepLastX", lastX, 159);
        checkOutput("sweepLastY", lastY, 119);
        checkOutput("sweepLastColour", lastC, 0);
        checkOutput("sweepExitPlot", int'(plot), 0);
        checkOutput("sweepExitGrant", int'(grant), 4'b0001);
        applyStimulus(4'b0000, 1'b0);
        @(negedge clk);
        checkOutput("postSweepPlot", int'(plot), 1);
        checkOutput("postSweepX", int'(x), 10);

        // Reset in the middle of a sweep aborts it
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b0);
        cnt = 0;
        for (int n = 0; n < 1000 && cnt < 500; n++) begin
            @(negedge clk);
            if (plot) cnt++;
        end
        checkOutput("abortReached500", cnt, 500);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        checkOutput("abortBusy", int'(clear_busy), 0);
        checkOutput("abortPlot", int'(plot), 0);
        checkOutput("abortX", int'(x), 0);
        checkOutput("abortPtrGrant", int'(grant), 4'b0001);
        applyStimulus(4'b0000, 1'b0);
        @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
